// File: rtl/tag_alloc288.sv
// -----------------------------------------------------------------------------
// tag_alloc288 -- allocator for a 288-entry tag pool.
//
// Keeps a 288-bit availability map (1 = free) and grants the highest-numbered
// free tag, at most one per cycle. Tags come back through the free port, and
// illegal frees raise a sticky error flag.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   flush       return every allocatable tag to the pool, clear free_err
//   alloc_req   request one tag this cycle
//   alloc_ack   registered pulse, alloc_tag is valid
//   alloc_tag   granted tag (9'd511 when no grant)
//   free_v      free_tag is being returned this cycle
//   free_tag    tag being returned
//   free_count  number of currently available tags
//   empty       free_count == 0
//   free_err    sticky illegal-free flag (out of range, reserved, double free)
//
// Parameter
//   LOW_RESERVE tags 0..LOW_RESERVE-1 are never handed out (0..287)
// -----------------------------------------------------------------------------

// Find-last-one over 288 bits: index of the highest set bit, 511 if none.
// Split into 18 groups of 16 so that the priority chain stays short.
module flo288 (
   input  logic [287:0] vec,
   output logic [8:0]   idx
);
   localparam int NG = 18;

   logic [NG-1:0]   grp_any;
   logic [NG*4-1:0] grp_lo_flat;

   genvar gi;
   generate
      for (gi = 0; gi < NG; gi++) begin : g_grp
         logic [3:0] lo;
         assign grp_any[gi] = |vec[gi*16 +: 16];
         always_comb begin
            lo = 4'd0;
            for (int b = 0; b < 16; b++) begin
               if (vec[gi*16 + b]) lo = 4'(b);
            end
         end
         assign grp_lo_flat[gi*4 +: 4] = lo;
      end
   endgenerate

   // Later (higher) groups override earlier ones.
   always_comb begin
      idx = 9'd511;
      for (int g = 0; g < NG; g++) begin
         if (grp_any[g]) idx = {g[4:0], grp_lo_flat[g*4 +: 4]};
      end
   end
endmodule

module tag_alloc288 #(
   parameter int LOW_RESERVE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       alloc_req,
   output logic       alloc_ack,
   output logic [8:0] alloc_tag,
   input  logic       free_v,
   input  logic [8:0] free_tag,
   output logic [8:0] free_count,
   output logic       empty,
   output logic       free_err
);
   localparam int         NTAG       = 288;
   localparam logic [8:0] INIT_COUNT = 9'(NTAG - LOW_RESERVE);
   localparam logic [8:0] NO_TAG     = 9'd511;

   // Map of tags that may ever be free: the reset/flush image of avail.
   logic [NTAG-1:0] init_map;

   genvar gi;
   generate
      for (gi = 0; gi < NTAG; gi++) begin : g_init
         assign init_map[gi] = (gi >= LOW_RESERVE);
      end
   endgenerate

   logic [NTAG-1:0] avail_reg, avail_next;
   logic [8:0]      count_reg, count_next;
   logic            ack_reg, ack_next;
   logic [8:0]      tag_reg, tag_next;
   logic            err_reg, err_next;

   logic [8:0] cand;
   logic       grant;
   logic       tag_in_range;
   logic       tag_free_now;
   logic       tag_allocatable;
   logic       free_ok;
   logic       free_bad;

   // Candidate is taken from the pre-update map, so a tag freed this cycle
   // is only grantable from the next cycle on.
   flo288 u_flo (
      .vec (avail_reg),
      .idx (cand)
   );

   // Out-of-range tags must not index the maps.
   assign tag_in_range    = (free_tag < 9'(NTAG));
   assign tag_free_now    = tag_in_range ? avail_reg[free_tag] : 1'b0;
   assign tag_allocatable = tag_in_range ? init_map[free_tag]  : 1'b0;

   // Flush wins over both ports. Freeing the tag granted this same cycle is
   // seen as a double free because the map still shows it as free.
   assign grant    = alloc_req & ~flush & (cand != NO_TAG);
   assign free_ok  = free_v & ~flush & tag_in_range & tag_allocatable & ~tag_free_now;
   assign free_bad = free_v & ~flush & ~free_ok;

   always_comb begin
      avail_next = avail_reg;
      count_next = count_reg;
      ack_next   = grant;
      tag_next   = grant ? cand : NO_TAG;
      err_next   = err_reg | free_bad;
      if (flush) begin
         avail_next = init_map;
         count_next = INIT_COUNT;
         err_next   = 1'b0;
      end else begin
         if (grant)   avail_next[cand]     = 1'b0;
         if (free_ok) avail_next[free_tag] = 1'b1;
         case ({grant, free_ok})
            2'b10:   count_next = count_reg - 9'd1;
            2'b01:   count_next = count_reg + 9'd1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avail_reg <= init_map;
         count_reg <= INIT_COUNT;
         ack_reg   <= 1'b0;
         tag_reg   <= NO_TAG;
         err_reg   <= 1'b0;
      end else begin
         avail_reg <= avail_next;
         count_reg <= count_next;
         ack_reg   <= ack_next;
         tag_reg   <= tag_next;
         err_reg   <= err_next;
      end
   end

   assign alloc_ack  = ack_reg;
   assign alloc_tag  = tag_reg;
   assign free_count = count_reg;
   assign empty      = (count_reg == 9'd0);
   assign free_err   = err_reg;
endmodule

// File: tb/tb_tag_alloc288.sv
// -----------------------------------------------------------------------------
// tb_tag_alloc288 -- bench for tag_alloc288. Two instances: LOW_RESERVE=0 and
// LOW_RESERVE=16. A behavioural model (plain bit map, linear search for the
// highest free tag, popcount for the occupancy) is compared against both
// instances on every falling edge, with a few literal expectations on top.
// -----------------------------------------------------------------------------
module tb_tag_alloc288;
   logic clk = 1'b0;
   logic rst;
   logic [1:0]      flush, req, fv;
   logic [1:0][8:0] ftag;
   logic [1:0]      ack, emp, ferr;
   logic [1:0][8:0] tag, cnt;

   int chk = 0;
   int err = 0;
   bit checking = 1'b0;

   bit [287:0] m_avail [2];
   bit         m_ack   [2];
   bit         m_err   [2];
   int         m_tag   [2];
   int         res     [2] = '{0, 16};

   always #5 clk = ~clk;

   tag_alloc288 #(.LOW_RESERVE(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush[0]), .alloc_req(req[0]),
      .alloc_ack(ack[0]), .alloc_tag(tag[0]), .free_v(fv[0]),
      .free_tag(ftag[0]), .free_count(cnt[0]), .empty(emp[0]),
      .free_err(ferr[0])
   );

   tag_alloc288 #(.LOW_RESERVE(16)) dut16 (
      .clk(clk), .rst(rst), .flush(flush[1]), .alloc_req(req[1]),
      .alloc_ack(ack[1]), .alloc_tag(tag[1]), .free_v(fv[1]),
      .free_tag(ftag[1]), .free_count(cnt[1]), .empty(emp[1]),
      .free_err(ferr[1])
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int highest_free(bit [287:0] a);
      for (int k = 287; k >= 0; k--) if (a[k]) return k;
      return 511;
   endfunction

   task automatic model_reset(int i);
      for (int k = 0; k < 288; k++) m_avail[i][k] = (k >= res[i]);
      m_ack[i] = 1'b0;
      m_tag[i] = 511;
      m_err[i] = 1'b0;
   endtask

   task automatic model_update(int i);
      int  c;
      bit  legal;
      int  t;
      if (flush[i]) begin
         model_reset(i);
      end else begin
         c = highest_free(m_avail[i]);
         t = int'(ftag[i]);
         legal = fv[i] && (t < 288) && (t >= res[i]) && !m_avail[i][t];
         if (fv[i] && !legal) m_err[i] = 1'b1;
         m_ack[i] = req[i] && (c != 511);
         if (m_ack[i]) m_avail[i][c] = 1'b0;
         if (legal) m_avail[i][t] = 1'b1;
         m_tag[i] = m_ack[i] ? c : 511;
      end
   endtask

   // One clock: inputs already set, model steps at the edge, return 1 after.
   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_update(0);
         model_update(1);
      end
      #1;
   endtask

   task automatic idle();
      flush = '0; req = '0; fv = '0; ftag = '0;
   endtask

   // Every-cycle compare against the model.
   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < 2; i++) begin
            int c;
            c = $countones(m_avail[i]);
            check($sformatf("ack%0d", i),   ack[i],  m_ack[i]);
            check($sformatf("tag%0d", i),   tag[i],  m_tag[i]);
            check($sformatf("count%0d", i), cnt[i],  c);
            check($sformatf("empty%0d", i), emp[i],  c == 0);
            check($sformatf("err%0d", i),   ferr[i], m_err[i]);
         end
      end
   end

   initial begin
      int n;
      int last;
      idle();
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      checking = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      check("rst_ack", ack[0], 0);
      check("rst_tag", tag[0], 511);
      check("rst_count0", cnt[0], 288);
      check("rst_count16", cnt[1], 272);
      check("rst_err", ferr[0], 0);
      $display("reset done: count0=%0d count16=%0d", cnt[0], cnt[1]);

      // Three back-to-back grants.
      req[0] = 1'b1;
      cycle(); check("grant1", tag[0], 287);
      cycle(); check("grant2", tag[0], 286);
      cycle(); check("grant3", tag[0], 285);
      check("count_after3", cnt[0], 285);
      $display("alloc x3: last tag=%0d count=%0d", tag[0], cnt[0]);

      // Drain the pool.
      repeat (285) cycle();
      check("last_tag0", tag[0], 0);
      check("empty_set", emp[0], 1);
      cycle();
      check("noack_empty", ack[0], 0);
      check("tag511_empty", tag[0], 511);
      $display("drain: empty=%0d", emp[0]);

      // Free 100, then grant it back.
      req[0] = 1'b0; fv[0] = 1'b1; ftag[0] = 9'd100;
      cycle();
      fv[0] = 1'b0; req[0] = 1'b1;
      cycle();
      check("regrant100", tag[0], 100);
      req[0] = 1'b0;
      $display("free/regrant: tag=%0d", tag[0]);

      // Simultaneous alloc and free.
      flush[0] = 1'b1; cycle(); flush[0] = 1'b0;
      req[0] = 1'b1;
      repeat (10) cycle();
      check("count_278", cnt[0], 278);
      fv[0] = 1'b1; ftag[0] = 9'd287;
      cycle();
      check("simul_tag", tag[0], 277);
      check("simul_count", cnt[0], 278);
      fv[0] = 1'b0;
      cycle();
      check("next_287", tag[0], 287);
      req[0] = 1'b0;
      cycle();
      $display("simultaneous: count=%0d", cnt[0]);

      // Illegal frees, stickiness, flush clear.
      fv[0] = 1'b1; ftag[0] = 9'd5;
      cycle();
      check("dbl_err", ferr[0], 1);
      check("dbl_count", cnt[0], 277);
      ftag[0] = 9'd300;
      cycle();
      check("range_err", ferr[0], 1);
      check("range_count", cnt[0], 277);
      fv[0] = 1'b0;
      cycle();
      check("err_sticky", ferr[0], 1);
      flush[0] = 1'b1; cycle(); flush[0] = 1'b0;
      check("flush_err", ferr[0], 0);
      check("flush_count", cnt[0], 288);
      $display("illegal frees: err cleared by flush, count=%0d", cnt[0]);

      // Reserved low tags.
      flush[1] = 1'b1; cycle(); flush[1] = 1'b0;
      req[1] = 1'b1;
      n = 0; last = -1;
      for (int k = 0; k < 300; k++) begin
         cycle();
         if (ack[1]) begin n++; last = int'(tag[1]); end
      end
      req[1] = 1'b0;
      check("res_grants", n, 272);
      check("res_last", last, 16);
      check("res_empty", emp[1], 1);
      fv[1] = 1'b1; ftag[1] = 9'd5;
      cycle();
      fv[1] = 1'b0;
      check("res_free_err", ferr[1], 1);
      $display("reserve16: grants=%0d last=%0d", n, last);

      // Randomized traffic on both instances.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 2; i++) begin
            flush[i] = ($urandom_range(0, 199) == 0);
            req[i]   = ($urandom_range(0, 2) != 0);
            fv[i]    = $urandom_range(0, 1) != 0;
            ftag[i]  = ($urandom_range(0, 9) < 8) ? 9'($urandom_range(0, 287))
                                                   : 9'($urandom_range(0, 511));
         end
         cycle();
      end
      idle();
      cycle();
      $display("random phase done: count0=%0d count16=%0d", cnt[0], cnt[1]);

      // Asynchronous reset during continuous allocation.
      flush = 2'b11; cycle(); flush = 2'b00;
      req[0] = 1'b1;
      repeat (5) cycle();
      #2;
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      #1;
      check("arst_ack", ack[0], 0);
      check("arst_tag", tag[0], 511);
      check("arst_count", cnt[0], 288);
      cycle();
      rst = 1'b0;
      check("post_rst_noack", ack[0], 0);
      cycle();
      check("post_rst_ack", ack[0], 1);
      check("post_rst_tag", tag[0], 287);
      req[0] = 1'b0;
      cycle();
      $display("async reset: next grant=287 observed");

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end
endmodule
